// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the core data port and the data SRAM.
// Stores drain through a req/ack FSM; loads forward from the youngest buffered entry.
module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 30,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          DREQ,
    input  logic [1:0]    DRW,
    input  logic [AW-1:0] DADDR,
    input  logic [DW-1:0] DWDATA,
    output logic [DW-1:0] DRDATA,
    output logic [AW-1:0] M_RADDR,
    input  logic [DW-1:0] M_RDATA,
    output logic          M_WREQ,
    output logic [AW-1:0] M_WADDR,
    output logic [DW-1:0] M_WDATA,
    input  logic          M_WACK,
    output logic          FULL,
    output logic          EMPTY,
    output logic          OVF
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_addr [DEPTH];
    logic [DW-1:0]       r_data [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_ovf;

    logic                w_store;
    logic                w_pop;
    logic                w_push;
    logic [CW-1:0]       w_count_nxt;
    logic                w_hit;
    logic [DW-1:0]       w_fwd;
    logic [PW-1:0]       w_idx;
    logic                w_unused;

    assign w_unused    = DRW[1];
    assign w_store     = DREQ & DRW[0];
    assign w_pop       = (r_state == S_ISSUE) & M_WACK;
    // A pop on the same edge frees the slot, so a store at full still fits.
    assign w_push      = w_store & ((r_count != CW'(DEPTH)) | w_pop);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_store && !w_push) begin
                r_ovf <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_state <= (w_count_nxt != '0) ? S_ISSUE : S_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= DADDR;
            r_data[r_wr_ptr] <= DWDATA;
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PW'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == DADDR)) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_idx];
            end
        end
    end

    assign DRDATA  = (DREQ && !DRW[0] && w_hit) ? w_fwd : M_RDATA;
    assign M_RADDR = DADDR;
    assign M_WREQ  = (r_state == S_ISSUE);
    assign M_WADDR = r_addr[r_rd_ptr];
    assign M_WDATA = r_data[r_rd_ptr];
    assign FULL    = (r_count == CW'(DEPTH));
    assign EMPTY   = (r_count == '0) && (r_state == S_IDLE);
    assign OVF     = r_ovf;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: directed vector table, then random traffic
// against a queue-based model of the buffer.
module tb_dmem_write_buffer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        DREQ;
    logic [1:0]  DRW;
    logic [29:0] DADDR;
    logic [31:0] DWDATA;
    logic [31:0] DRDATA;
    logic [29:0] M_RADDR;
    logic [31:0] M_RDATA;
    logic        M_WREQ;
    logic [29:0] M_WADDR;
    logic [31:0] M_WDATA;
    logic        M_WACK;
    logic        FULL;
    logic        EMPTY;
    logic        OVF;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    dmem_write_buffer #(.DEPTH(4), .AW(30), .DW(32)) dut (
        .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
        .DWDATA(DWDATA), .DRDATA(DRDATA), .M_RADDR(M_RADDR),
        .M_RDATA(M_RDATA), .M_WREQ(M_WREQ), .M_WADDR(M_WADDR),
        .M_WDATA(M_WDATA), .M_WACK(M_WACK), .FULL(FULL), .EMPTY(EMPTY),
        .OVF(OVF)
    );

    typedef struct {
        logic        rst, dreq, wr;
        logic [29:0] addr;
        logic [31:0] wdata, rdata;
        logic        wack;
        logic        ewreq;
        logic [29:0] ewaddr;
        logic [31:0] ewdata;
        logic        efull, eempty, eovf;
        logic [31:0] erd;
    } vec_t;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    vec_t tv[$];
    ent_t q[$];

    function automatic vec_t v(logic rst, logic dreq, logic wr,
                               logic [29:0] a, logic [31:0] wd,
                               logic [31:0] rd, logic wack, logic ewreq,
                               logic [29:0] ewa, logic [31:0] ewd,
                               logic ef, logic ee, logic eo,
                               logic [31:0] erd);
        vec_t r;
        r.rst = rst; r.dreq = dreq; r.wr = wr; r.addr = a;
        r.wdata = wd; r.rdata = rd; r.wack = wack; r.ewreq = ewreq;
        r.ewaddr = ewa; r.ewdata = ewd; r.efull = ef; r.eempty = ee;
        r.eovf = eo; r.erd = erd;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic drive(logic rst, logic dreq, logic wr, logic [29:0] a,
                         logic [31:0] wd, logic [31:0] rd, logic wack);
        RST = rst; DREQ = dreq; DRW = {1'b0, wr}; DADDR = a;
        DWDATA = wd; M_RDATA = rd; M_WACK = wack;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("t1_wreq", 32'(M_WREQ), 32'd0);
        chk("t1_empty", 32'(EMPTY), 32'd1);
        chk("t1_full", 32'(FULL), 32'd0);
        chk("t1_ovf", 32'(OVF), 32'd0);

        // T2 single store, ack tied high
        tv.push_back(v(0,1,1,'h10,'hDEADBEEF,0,1, 0,0,0, 0,1,0,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,'h10,'hDEADBEEF, 0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0, 0,0,0, 0,1,0,0));
        // T3 forwarding, youngest wins, popped head still forwards
        tv.push_back(v(0,1,1,'h20,1,0,0, 0,0,0, 0,1,0,0));
        tv.push_back(v(0,1,1,'h20,2,0,0, 1,'h20,1, 0,0,0,0));
        tv.push_back(v(0,1,0,'h20,0,'h99,0, 1,'h20,1, 0,0,0,2));
        tv.push_back(v(0,1,0,'h24,0,'h55,0, 1,'h20,1, 0,0,0,'h55));
        tv.push_back(v(0,1,0,'h20,0,'h99,1, 1,'h20,1, 0,0,0,2));
        tv.push_back(v(0,1,0,'h20,0,'h77,1, 1,'h20,2, 0,0,0,2));
        tv.push_back(v(0,1,0,'h20,0,'h77,0, 0,0,0, 0,1,0,'h77));
        // T4 fill, overflow, drain in order
        tv.push_back(v(0,1,1,'h100,'hA0,0,0, 0,0,0, 0,1,0,0));
        tv.push_back(v(0,1,1,'h101,'hA1,0,0, 1,'h100,'hA0, 0,0,0,0));
        tv.push_back(v(0,1,1,'h102,'hA2,0,0, 1,'h100,'hA0, 0,0,0,0));
        tv.push_back(v(0,1,1,'h103,'hA3,0,0, 1,'h100,'hA0, 0,0,0,0));
        tv.push_back(v(0,1,1,'h104,'hA4,0,0, 1,'h100,'hA0, 1,0,0,0));
        tv.push_back(v(0,1,0,'h104,0,'h44,0, 1,'h100,'hA0, 1,0,1,'h44));
        tv.push_back(v(0,1,0,'h101,0,0,0, 1,'h100,'hA0, 1,0,1,'hA1));
        tv.push_back(v(0,0,0,0,0,0,1, 1,'h100,'hA0, 1,0,1,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,'h101,'hA1, 0,0,1,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,'h102,'hA2, 0,0,1,0));
        tv.push_back(v(0,0,0,0,0,0,1, 1,'h103,'hA3, 0,0,1,0));
        tv.push_back(v(0,0,0,0,0,0,0, 0,0,0, 0,1,1,0));
        tv.push_back(v(1,0,0,0,0,0,0, 0,0,0, 0,1,1,0));
        tv.push_back(v(0,0,0,0,0,0,0, 0,0,0, 0,1,0,0));
        // T5 push+pop at full, write pointer wraps
        tv.push_back(v(0,1,1,'h200,'hB0,0,0, 0,0,0, 0,1,0,0));
        tv.push_back(v(0,1,1,'h201,'hB1,0,0, 1,'h200,'hB0, 0,0,0,0));
        tv.push_back(v(0,1,1,'h202,'hB2,0,0, 1,'h200,'hB0, 0,0,0,0));
        tv.push_back(v(0,1,1,'h203,'hB3,0,0, 1,'h200,'hB0, 0,0,0,0));
        tv.push_back(v(0,1,1,'h204,'hB4,0,1, 1,'h200,'hB0, 1,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0, 1,'h201,'hB1, 1,0,0,0));
        tv.push_back(v(0,1,0,'h204,0,0,0, 1,'h201,'hB1, 1,0,0,'hB4));
        // T6 reset mid-drain
        tv.push_back(v(0,0,0,0,0,0,1, 1,'h201,'hB1, 1,0,0,0));
        tv.push_back(v(1,0,0,0,0,0,0, 1,'h202,'hB2, 0,0,0,0));
        tv.push_back(v(0,1,0,'h203,0,'h33,1, 0,0,0, 0,1,0,'h33));
        tv.push_back(v(0,0,0,0,0,0,0, 0,0,0, 0,1,0,0));

        foreach (tv[k]) begin
            drive(tv[k].rst, tv[k].dreq, tv[k].wr, tv[k].addr,
                  tv[k].wdata, tv[k].rdata, tv[k].wack);
            #1;
            chk($sformatf("v%0d_wreq", k), 32'(M_WREQ), 32'(tv[k].ewreq));
            chk($sformatf("v%0d_full", k), 32'(FULL), 32'(tv[k].efull));
            chk($sformatf("v%0d_empty", k), 32'(EMPTY), 32'(tv[k].eempty));
            chk($sformatf("v%0d_ovf", k), 32'(OVF), 32'(tv[k].eovf));
            if (tv[k].ewreq) begin
                chk($sformatf("v%0d_waddr", k), 32'(M_WADDR),
                    32'(tv[k].ewaddr));
                chk($sformatf("v%0d_wdata", k), M_WDATA, tv[k].ewdata);
            end
            if (tv[k].dreq && !tv[k].wr) begin
                chk($sformatf("v%0d_drdata", k), DRDATA, tv[k].erd);
            end
            tick();
        end

        begin
            bit          m_wreq;
            bit          m_ovf;
            bit          rst, dreq, wr, wack, pop, push;
            logic [29:0] a;
            logic [31:0] wd, rd, exp_rd;

            drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            tick();
            q.delete();
            m_wreq = 0;
            m_ovf = 0;
            for (int c = 0; c < 800; c++) begin
                rst  = ($urandom_range(0, 79) == 0);
                dreq = $urandom_range(0, 1) == 1;
                wr   = $urandom_range(0, 99) < 55;
                wack = $urandom_range(0, 99) < 40;
                a    = 30'($urandom_range(0, 5));
                wd   = $urandom;
                rd   = $urandom;
                drive(rst, dreq, wr, a, wd, rd, wack);
                DRW[1] = 1'($urandom_range(0, 1));
                #1;
                exp_rd = rd;
                foreach (q[j]) if (q[j].a == a) exp_rd = q[j].d;
                chk("r_wreq", 32'(M_WREQ), 32'(m_wreq));
                chk("r_full", 32'(FULL), 32'(q.size() == 4));
                chk("r_empty", 32'(EMPTY), 32'(q.size() == 0 && !m_wreq));
                chk("r_ovf", 32'(OVF), 32'(m_ovf));
                chk("r_raddr", 32'(M_RADDR), 32'(a));
                if (m_wreq && q.size() > 0) begin
                    chk("r_waddr", 32'(M_WADDR), 32'(q[0].a));
                    chk("r_wdata", M_WDATA, q[0].d);
                end
                if (dreq && !wr) chk("r_drdata", DRDATA, exp_rd);
                if (rst) begin
                    q.delete();
                    m_wreq = 0;
                    m_ovf = 0;
                end else begin
                    pop  = m_wreq && wack;
                    push = dreq && wr && (q.size() < 4 || pop);
                    if (dreq && wr && !push) m_ovf = 1;
                    if (pop) void'(q.pop_front());
                    if (push) q.push_back('{a: a, d: wd});
                    m_wreq = (q.size() > 0);
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
